umul_add: RTL

- Sequential unsigned multiply-accumulate: computes product = multiplicand * multiplier + addend using shift-add, one multiplier bit per cycle.
- Inverse companion to the team's unsigned divider: feeding it {quotient, divisor, remainder} reconstructs the dividend.
- Uses the same ce / input_data_valid / input_ready_for_data / output_data_valid handshake, so it drops into the same datapaths and self-check loops.

---
 rtl/umul_add_if.sv | 44 ++++
 rtl/umul_add.sv | 133 +++++++++++++
 2 files changed

// File: rtl/umul_add_if.sv
// Operand/result bus for umul_add.
// Handshake: operands are taken on a rising clk edge where ce, input_data_valid
// and input_ready_for_data are all high; output_data_valid is a one-ce-edge
// strobe marking product/overflow as fresh, so consumers qualify it with ce.
// dbg_state mirrors the internal FSM state for observation only.
interface umul_add_if #(
    parameter int DWIDTH = 8
);
    logic                  input_data_valid;
    logic                  input_ready_for_data;
    logic [DWIDTH-1:0]     multiplicand;
    logic [DWIDTH-1:0]     multiplier;
    logic [DWIDTH-1:0]     addend;
    logic                  output_data_valid;
    logic [2*DWIDTH-1:0]   product;
    logic                  overflow;
    logic [1:0]            dbg_state;

    // Producer/consumer side (testbench or surrounding datapath)
    modport master (
        output input_data_valid,
        output multiplicand,
        output multiplier,
        output addend,
        input  input_ready_for_data,
        input  output_data_valid,
        input  product,
        input  overflow,
        input  dbg_state
    );

    // Multiplier side
    modport slave (
        input  input_data_valid,
        input  multiplicand,
        input  multiplier,
        input  addend,
        output input_ready_for_data,
        output output_data_valid,
        output product,
        output overflow,
        output dbg_state
    );
endinterface

// File: rtl/umul_add.sv
// umul_add: sequential unsigned multiply-accumulate, product = A*B + addend.
// Shift-add, one multiplier bit per ce edge; DWIDTH CALC edges plus one DONE
// edge per operation. Optional macro UMUL_OVERFLOW_EN adds an overflow flag
// (high result half non-zero); without it overflow is tied to 0.
module umul_add #(
    parameter int DWIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    umul_add_if.slave  bus
);
    localparam int PW = 2 * DWIDTH;
    localparam int CW = $clog2(DWIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] LAST_BIT = CW'(DWIDTH - 1);

    logic [1:0]        state_q,   state_d;
    logic [CW-1:0]     counter_q, counter_d;
    logic [DWIDTH-1:0] mcand_q,   mcand_d;
    logic [DWIDTH-1:0] mplier_q,  mplier_d;
    logic [PW-1:0]     acc_q,     acc_d;
    logic              ready_q,   ready_d;
    logic              valid_q,   valid_d;
    logic [PW-1:0]     product_q, product_d;

    // Multiplicand aligned to the bit weight currently being processed
    logic [PW-1:0]     partial;
    assign partial = PW'(mcand_q) << counter_q;

    // Next-state logic for the shift-add sequencer
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        ready_d   = ready_q;
        valid_d   = 1'b0;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
                if (bus.input_data_valid && ready_q) begin
                    mcand_d   = bus.multiplicand;
                    mplier_d  = bus.multiplier;
                    acc_d     = PW'(bus.addend);
                    counter_d = '0;
                    ready_d   = 1'b0;
                    state_d   = S_CALC;
                end
            end
            S_CALC: begin
                // Sum never exceeds 2^(2W) - 2^W, so the PW-bit add cannot wrap
                if (mplier_q[counter_q]) begin
                    acc_d = acc_q + partial;
                end
                counter_d = counter_q + CW'(1);
                if (counter_q == LAST_BIT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                product_d = acc_q;
                valid_d   = 1'b1;
                ready_d   = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                ready_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers: reset wins over ce, otherwise update only on ce edges
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            counter_q <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            ready_q   <= 1'b0;
            valid_q   <= 1'b0;
            product_q <= '0;
        end else if (ce) begin
            state_q   <= state_d;
            counter_q <= counter_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            product_q <= product_d;
        end
    end

`ifdef UMUL_OVERFLOW_EN
    logic overflow_q, overflow_d;

    // Overflow captured with the product: result does not fit DWIDTH bits
    always_comb begin
        overflow_d = overflow_q;
        if (state_q == S_DONE) begin
            overflow_d = |acc_q[PW-1:DWIDTH];
        end
    end

    // Overflow register shares the reset/ce behaviour of product
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (ce) begin
            overflow_q <= overflow_d;
        end
    end

    assign bus.overflow = overflow_q;
`else
    assign bus.overflow = 1'b0;
`endif

    assign bus.input_ready_for_data = ready_q;
    assign bus.output_data_valid    = valid_q;
    assign bus.product              = product_q;
    assign bus.dbg_state            = state_q;

endmodule
